mem_stage: RTL

- Memory-access pipeline stage of the MIPS64 core. Sits between the execute stage and the writeback stage.
- Issues load/store requests to the data memory over a req/ack handshake and stalls the upstream pipeline while a request is outstanding.
- Performs byte-lane steering and sign/zero extension of load data.
- Registers everything the writeback stage consumes (the MEM/WB pipeline register).

---
 rtl/mem_stage_pkg.sv | 23 ++
 rtl/mem_load_align.sv | 21 ++
 rtl/mem_stage.sv | 118 +++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, size/control encodings, FSM states and lane helpers for the MEM stage
package mem_stage_pkg;
  localparam int P_WIDTH        = 64;
  localparam int P_ADDR         = 5;
  localparam int P_WB_CTRL_SIZE = 5;
  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;
  localparam int CTRL_STORE    = 4;
  localparam int CTRL_LOAD     = 3;
  localparam int CTRL_JUMP     = 2;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMTOREG = 0;
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;
  function automatic logic [7:0] f_size_mask(input logic [1:0] size);
    return size == SZ_BYTE ? 8'h01 : size == SZ_HALF ? 8'h03 : size == SZ_WORD ? 8'h0F : 8'hFF;
  endfunction
  function automatic logic f_aligned(input logic [1:0] size, input logic [2:0] off);
    return size == SZ_BYTE ? 1'b1 : size == SZ_HALF ? !off[0] :
           size == SZ_WORD ? off[1:0] == 2'b00 : off == 3'b000;
  endfunction
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: extracts the addressed lane from a read doubleword and sign/zero extends it
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [63:0] i_rdata,
  input  logic [2:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [63:0] o_data
);
  logic [63:0] w_sh;
  logic        w_sx;
  // shift the addressed byte down to lane 0, then extend to the access size
  always_comb begin
    w_sh   = i_rdata >> {i_offset, 3'b000};
    w_sx   = !i_unsigned;
    o_data = i_size == SZ_BYTE ? {{56{w_sx & w_sh[7]}},  w_sh[7:0]}  :
             i_size == SZ_HALF ? {{48{w_sx & w_sh[15]}}, w_sh[15:0]} :
             i_size == SZ_WORD ? {{32{w_sx & w_sh[31]}}, w_sh[31:0]} : w_sh;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS64 memory stage with req/ack data-memory handshake and MEM/WB pipeline register
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int WIDTH        = P_WIDTH,
  parameter int ADDR         = P_ADDR,
  parameter int WB_CTRL_SIZE = P_WB_CTRL_SIZE
) (
  input  logic                    p_Clk,
  input  logic                    p_Rst_n,
  input  logic                    p_MEM_Valid,
  input  logic [WIDTH-1:0]        p_MEM_ALUResult,
  input  logic [WIDTH-1:0]        p_MEM_StoreData,
  input  logic [ADDR-1:0]         p_MEM_RegDestIN,
  input  logic [WIDTH-1:0]        p_MEM_PC_4,
  input  logic [WB_CTRL_SIZE-1:0] p_MEM_Ctrl_Bus,
  input  logic [1:0]              p_MEM_Size,
  input  logic                    p_MEM_Unsigned,
  output logic                    p_MEM_Stall,
  output logic                    p_DMem_Req,
  output logic                    p_DMem_We,
  output logic [WIDTH-1:0]        p_DMem_Addr,
  output logic [WIDTH-1:0]        p_DMem_WData,
  output logic [7:0]              p_DMem_ByteEn,
  input  logic                    p_DMem_Ack,
  input  logic [WIDTH-1:0]        p_DMem_RData,
  output logic                    p_WB_Valid,
  output logic [WIDTH-1:0]        p_WB_MemData,
  output logic [WIDTH-1:0]        p_WB_ALUResult,
  output logic [ADDR-1:0]         p_WB_RegDestIN,
  output logic [WIDTH-1:0]        p_WB_PC_4,
  output logic [WB_CTRL_SIZE-1:0] p_WB_Ctrl_Bus,
  output logic                    p_MEM_AlignErr
);
  state_t                  r_state;
  logic [1:0]              r_size;
  logic                    r_unsigned;
  logic [2:0]              r_off;
  logic                    w_idle, w_memop, w_aligned, w_issue, w_misal, w_done, w_bubble;
  logic [WIDTH-1:0]        w_wdata, w_load;
  logic [7:0]              w_byteen;
  logic [WB_CTRL_SIZE-1:0] w_ctrl_fix;
  mem_load_align u_align (
    .i_rdata   (p_DMem_RData),
    .i_offset  (r_off),
    .i_size    (r_size),
    .i_unsigned(r_unsigned),
    .o_data    (w_load)
  );
  // classify the presented instruction and steer store data into its byte lanes
  always_comb begin
    w_idle     = r_state == S_IDLE;
    w_memop    = p_MEM_Valid && (p_MEM_Ctrl_Bus[CTRL_STORE] || p_MEM_Ctrl_Bus[CTRL_LOAD]);
    w_aligned  = f_aligned(p_MEM_Size, p_MEM_ALUResult[2:0]);
    w_issue    = w_idle && w_memop && w_aligned;
    w_misal    = w_idle && w_memop && !w_aligned;
    w_done     = !w_idle && p_DMem_Ack;
    w_bubble   = w_issue || (!w_idle && !p_DMem_Ack);
    w_wdata    = p_MEM_Size == SZ_BYTE ? {8{p_MEM_StoreData[7:0]}}  :
                 p_MEM_Size == SZ_HALF ? {4{p_MEM_StoreData[15:0]}} :
                 p_MEM_Size == SZ_WORD ? {2{p_MEM_StoreData[31:0]}} : p_MEM_StoreData;
    w_byteen   = f_size_mask(p_MEM_Size) << p_MEM_ALUResult[2:0];
    w_ctrl_fix = p_MEM_Ctrl_Bus;
    w_ctrl_fix[CTRL_REGWRITE] = 1'b0;
  end
  // stall is forced low while reset is held so upstream never freezes on a dead request
  assign p_MEM_Stall = p_Rst_n && w_bubble;
  assign p_DMem_Req  = r_state == S_WAIT;
  // request FSM: capture an aligned op in IDLE, hold it stable in WAIT until ack
  always_ff @(posedge p_Clk or negedge p_Rst_n) begin
    if (!p_Rst_n) begin
      r_state       <= S_IDLE;
      p_DMem_We     <= 1'b0;
      p_DMem_Addr   <= '0;
      p_DMem_WData  <= '0;
      p_DMem_ByteEn <= '0;
      r_size        <= SZ_BYTE;
      r_unsigned    <= 1'b0;
      r_off         <= '0;
    end else if (w_issue) begin
      r_state       <= S_WAIT;
      p_DMem_We     <= p_MEM_Ctrl_Bus[CTRL_STORE];
      p_DMem_Addr   <= {p_MEM_ALUResult[WIDTH-1:3], 3'b000};
      p_DMem_WData  <= w_wdata;
      p_DMem_ByteEn <= w_byteen;
      r_size        <= p_MEM_Size;
      r_unsigned    <= p_MEM_Unsigned;
      r_off         <= p_MEM_ALUResult[2:0];
    end else if (w_done) begin
      r_state       <= S_IDLE;
    end
  end
  // MEM/WB register: bubble while a request is pending, otherwise the presented instruction
  always_ff @(posedge p_Clk or negedge p_Rst_n) begin
    if (!p_Rst_n) begin
      p_WB_Valid     <= 1'b0;
      p_WB_MemData   <= '0;
      p_WB_ALUResult <= '0;
      p_WB_RegDestIN <= '0;
      p_WB_PC_4      <= '0;
      p_WB_Ctrl_Bus  <= '0;
      p_MEM_AlignErr <= 1'b0;
    end else if (w_bubble) begin
      p_WB_Valid     <= 1'b0;
      p_WB_MemData   <= '0;
      p_WB_Ctrl_Bus  <= '0;
      p_MEM_AlignErr <= 1'b0;
    end else begin
      p_WB_Valid     <= w_idle ? p_MEM_Valid : 1'b1;
      p_WB_MemData   <= (w_done && !p_DMem_We) ? w_load : '0;
      p_WB_ALUResult <= p_MEM_ALUResult;
      p_WB_RegDestIN <= p_MEM_RegDestIN;
      p_WB_PC_4      <= p_MEM_PC_4;
      p_WB_Ctrl_Bus  <= w_misal ? w_ctrl_fix : p_MEM_Ctrl_Bus;
      p_MEM_AlignErr <= w_misal;
    end
  end
endmodule
